// File: rtl/alu_rr_sequencer.sv
// alu_rr_sequencer
// ----------------
// Shares a single 4-bit, 12-function ALU between two command requesters.
// A round-robin arbiter picks one requester while the sequencer is idle, the
// command's operands are captured, the ALU result is computed and registered
// one cycle later, and the response is then held until the consumer takes it.
// The sequencer accepts at most one command per three clocks, and it accepts
// nothing while a command is executing or a response is pending.
//
// Optional feature macro: ALU_STATS_EN
//   defined   -> per-requester 8-bit saturating completion counters
//   undefined -> no counter registers; stat0_cnt/stat1_cnt are tied to 0
//
// Ports
//   clk, rst_n                    clock (rising edge), async active-low reset
//   req0_valid/ready/op/a/b       requester 0 command channel
//   req1_valid/ready/op/a/b       requester 1 command channel
//   resp_valid/ready              response handshake
//   resp_data                     ALU result (7 bits)
//   resp_id                       index of the requester that issued the command
//   resp_err                      illegal opcode or divide by zero
//   stat0_cnt, stat1_cnt          completion counters (ALU_STATS_EN only)

module alu_rr_sequencer #(
  parameter int OPW  = 4,
  parameter int RESW = 7,
  parameter int OPCW = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [OPCW-1:0] req0_op,
  input  logic [OPW-1:0]  req0_a,
  input  logic [OPW-1:0]  req0_b,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [OPCW-1:0] req1_op,
  input  logic [OPW-1:0]  req1_a,
  input  logic [OPW-1:0]  req1_b,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [RESW-1:0] resp_data,
  output logic            resp_id,
  output logic            resp_err,
  output logic [7:0]      stat0_cnt,
  output logic [7:0]      stat1_cnt
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t          state;
  logic            rr;
  logic [OPCW-1:0] op_q;
  logic [OPW-1:0]  a_q;
  logic [OPW-1:0]  b_q;
  logic            id_q;

  logic            grant0;
  logic            grant1;
  logic [RESW-1:0] a_x;
  logic [RESW-1:0] b_x;
  logic [RESW-1:0] alu_res;
  logic            alu_err;
  logic            resp_fire;

  // A lone valid requester always wins; on contention the rr pointer decides.
  // Ready is masked while in reset so nothing appears accepted then.
  assign grant0     = req0_valid && (!req1_valid || !rr);
  assign grant1     = req1_valid && (!req0_valid || rr);
  assign req0_ready = rst_n && (state == IDLE) && grant0;
  assign req1_ready = rst_n && (state == IDLE) && grant1;
  assign resp_fire  = resp_valid && resp_ready;

  // Operands are zero-extended to the result width so every operation
  // naturally wraps modulo 128 and the inverting ops cover all 7 bits.
  assign a_x = {{(RESW-OPW){1'b0}}, a_q};
  assign b_x = {{(RESW-OPW){1'b0}}, b_q};

  // ALU datapath working on the captured command.
  always_comb begin
    alu_res = '0;
    alu_err = 1'b0;
    case (op_q)
      4'd0: alu_res = a_x + b_x;
      4'd1: alu_res = a_x - b_x;
      4'd2: alu_res = a_x * b_x;
      4'd3: begin
        if (b_q == '0) begin
          alu_res = '1;
          alu_err = 1'b1;
        end else begin
          alu_res = a_x / b_x;
        end
      end
      4'd4:  alu_res = a_x << 1;
      4'd5:  alu_res = a_x >> 1;
      4'd6:  alu_res = a_x & b_x;
      4'd7:  alu_res = a_x | b_x;
      4'd8:  alu_res = a_x ^ b_x;
      4'd9:  alu_res = ~(a_x | b_x);
      4'd10: alu_res = ~(a_x & b_x);
      4'd11: alu_res = ~(a_x ^ b_x);
      default: begin
        alu_res = '0;
        alu_err = 1'b1;
      end
    endcase
  end

  // Sequencer: capture on accept, register the result in EXEC, then hold the
  // response until it is taken. The rr pointer flips to favour the requester
  // that was not just served.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rr         <= 1'b0;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      id_q       <= 1'b0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_id    <= 1'b0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req0_ready) begin
            op_q  <= req0_op;
            a_q   <= req0_a;
            b_q   <= req0_b;
            id_q  <= 1'b0;
            state <= EXEC;
          end else if (req1_ready) begin
            op_q  <= req1_op;
            a_q   <= req1_a;
            b_q   <= req1_b;
            id_q  <= 1'b1;
            state <= EXEC;
          end
        end
        EXEC: begin
          resp_data  <= alu_res;
          resp_err   <= alu_err;
          resp_id    <= id_q;
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            rr         <= ~resp_id;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ALU_STATS_EN
  logic [7:0] cnt0_q;
  logic [7:0] cnt1_q;

  // Completion counters stop at 8'hFF rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else if (resp_fire) begin
      if (!resp_id && (cnt0_q != 8'hFF)) cnt0_q <= cnt0_q + 8'd1;
      if (resp_id && (cnt1_q != 8'hFF))  cnt1_q <= cnt1_q + 8'd1;
    end
  end

  assign stat0_cnt = cnt0_q;
  assign stat1_cnt = cnt1_q;
`else
  logic unused_fire;
  assign unused_fire = resp_fire;
  assign stat0_cnt   = 8'd0;
  assign stat1_cnt   = 8'd0;
`endif

endmodule

// File: tb/tb_alu_rr_sequencer.sv
// Testbench for alu_rr_sequencer: drivers issue commands, a negedge monitor
// predicts grants, queues expected responses from an arithmetic reference
// model and compares them whenever a response is presented.

module tb_alu_rr_sequencer;

  logic       clk;
  logic       rst_n;
  logic       req0_valid;
  logic       req0_ready;
  logic [3:0] req0_op;
  logic [3:0] req0_a;
  logic [3:0] req0_b;
  logic       req1_valid;
  logic       req1_ready;
  logic [3:0] req1_op;
  logic [3:0] req1_a;
  logic [3:0] req1_b;
  logic       resp_valid;
  logic       resp_ready;
  logic [6:0] resp_data;
  logic       resp_id;
  logic       resp_err;
  logic [7:0] stat0_cnt;
  logic [7:0] stat1_cnt;

  int tests_run    = 0;
  int tests_failed = 0;

  // 0: resp_ready always high, 1: always low, 2: random
  int rr_mode = 0;

  // Scoreboard / model state
  int sb[$];
  int busy      = 0;
  int rr_m      = 0;
  int cycle     = 0;
  int acc_cycle = 0;
  int in_resp   = 0;
  int s0_m      = 0;
  int s1_m      = 0;

  alu_rr_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_op    (req0_op),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_op    (req1_op),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_id    (resp_id),
    .resp_err   (resp_err),
    .stat0_cnt  (stat0_cnt),
    .stat1_cnt  (stat1_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: returns err*128 + data using plain integer arithmetic.
  function automatic int ref_result(input int op, input int a, input int b);
    case (op)
      0:  return (a + b) % 128;
      1:  return (a - b + 128) % 128;
      2:  return (a * b) % 128;
      3:  return (b == 0) ? (128 + 127) : (a / b);
      4:  return (a * 2) % 128;
      5:  return a / 2;
      6:  return a & b;
      7:  return a | b;
      8:  return a ^ b;
      9:  return 127 - (a | b);
      10: return 127 - (a & b);
      11: return 127 - (a ^ b);
      default: return 128;
    endcase
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
               name, actual, actual, expected, expected, cycle);
    end
  endtask

  // Present a command on one port (called just after a rising edge) and hold
  // it until the DUT accepts it; returns just after the accepting edge.
  task automatic applyStimulus(input int port, input int op, input int a, input int b);
    int ok;
    ok = 0;
    if (port == 0) begin
      req0_op = 4'(op); req0_a = 4'(a); req0_b = 4'(b); req0_valid = 1'b1;
    end else begin
      req1_op = 4'(op); req1_a = 4'(a); req1_b = 4'(b); req1_valid = 1'b1;
    end
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if ((port == 0) ? req0_ready : req1_ready) begin
        ok = 1;
        break;
      end
    end
    @(posedge clk);
    #1;
    if (port == 0) req0_valid = 1'b0;
    else           req1_valid = 1'b0;
    if (ok == 0) checkOutput("accept_timeout", ok, 1);
  endtask

  // Wait (bounded) until no command is pending anywhere.
  task automatic waitIdle();
    int ok;
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !resp_valid && !req0_valid && !req1_valid) begin
        ok = 1;
        break;
      end
    end
    if (ok == 0) checkOutput("drain_timeout", ok, 1);
    @(posedge clk);
    #1;
  endtask

  // Response consumer
  initial begin
    resp_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rr_mode == 0)      resp_ready = 1'b1;
      else if (rr_mode == 1) resp_ready = 1'b0;
      else                   resp_ready = 1'($urandom_range(0, 1));
    end
  end

  // Monitor: predicts grants, pushes expected responses and checks them.
  always @(negedge clk) begin
    int e0, e1, exp_v, exp_s0, exp_s1;
    cycle++;
    if (!rst_n) begin
      sb.delete();
      busy = 0; rr_m = 0; in_resp = 0; s0_m = 0; s1_m = 0;
      checkOutput("reset_outputs",
                  {resp_valid, resp_data, resp_id, resp_err, req0_ready, req1_ready,
                   stat0_cnt, stat1_cnt}, 0);
    end else begin
      e0 = (busy == 0 && req0_valid && (!req1_valid || rr_m == 0)) ? 1 : 0;
      e1 = (busy == 0 && req1_valid && (!req0_valid || rr_m == 1)) ? 1 : 0;
      checkOutput("grant", {req1_ready, req0_ready}, e1 * 2 + e0);
      if (req0_valid && req0_ready) begin
        sb.push_back(ref_result(int'(req0_op), int'(req0_a), int'(req0_b)));
        busy = 1; acc_cycle = cycle;
      end else if (req1_valid && req1_ready) begin
        sb.push_back(256 + ref_result(int'(req1_op), int'(req1_a), int'(req1_b)));
        busy = 1; acc_cycle = cycle;
      end
`ifdef ALU_STATS_EN
      exp_s0 = s0_m; exp_s1 = s1_m;
`else
      exp_s0 = 0; exp_s1 = 0;
`endif
      checkOutput("stats", {stat1_cnt, stat0_cnt}, exp_s1 * 256 + exp_s0);
      if (resp_valid) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_resp", 1, 0);
        end else begin
          exp_v = sb[0];
          checkOutput("resp", {resp_id, resp_err, resp_data}, exp_v);
          if (in_resp == 0) checkOutput("latency", cycle - acc_cycle, 2);
          in_resp = 1;
          if (resp_ready) begin
            void'(sb.pop_front());
            busy = 0; in_resp = 0;
            rr_m = (exp_v >= 256) ? 0 : 1;
            if (exp_v >= 256) begin
              if (s1_m < 255) s1_m++;
            end else begin
              if (s0_m < 255) s0_m++;
            end
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int exp3, exp2, exp_sat;
    rst_n = 1'b0;
    req0_valid = 1'b0; req0_op = '0; req0_a = '0; req0_b = '0;
    req1_valid = 1'b0; req1_op = '0; req1_a = '0; req1_b = '0;
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Both requesters valid from reset, held: p0 first, then alternating.
    fork
      for (int i = 0; i < 3; i++) applyStimulus(0, 2, 15, 15);
      for (int i = 0; i < 3; i++) applyStimulus(1, 1, 2, 5);
    join
    waitIdle();

    // Single command on port 0.
    applyStimulus(0, 0, 9, 8);
    waitIdle();

    // Error cases on port 1.
    applyStimulus(1, 3, 7, 0);
    applyStimulus(1, 13, 4, 4);
    applyStimulus(1, 9, 0, 0);
    waitIdle();

    // Backpressure: response stalled while port 0 keeps requesting.
    rr_mode = 1;
    @(posedge clk); #1;
    applyStimulus(0, 7, 5, 3);
    fork
      applyStimulus(0, 8, 6, 3);
      begin
        for (int i = 0; i < 20; i++) begin
          @(negedge clk);
          if (resp_valid) break;
        end
        repeat (5) @(negedge clk);
        rr_mode = 0;
      end
    join
    waitIdle();

    // Reset pulsed while the command is executing: it must vanish.
    applyStimulus(0, 0, 3, 4);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    @(posedge clk); #1;

    // Three port-0 and two port-1 completions after reset.
    for (int i = 0; i < 3; i++) applyStimulus(0, 6, i, 15);
    for (int i = 0; i < 2; i++) applyStimulus(1, 4, i + 3, 1);
    waitIdle();
`ifdef ALU_STATS_EN
    exp3 = 3; exp2 = 2; exp_sat = 255;
`else
    exp3 = 0; exp2 = 0; exp_sat = 0;
`endif
    checkOutput("stat0_after_3", int'(stat0_cnt), exp3);
    checkOutput("stat1_after_2", int'(stat1_cnt), exp2);

    // Randomised traffic on both ports with random backpressure.
    rr_mode = 2;
    fork
      for (int i = 0; i < 40; i++) begin
        repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        applyStimulus(0, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));
      end
      for (int i = 0; i < 40; i++) begin
        repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        applyStimulus(1, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));
      end
    join
    rr_mode = 0;
    waitIdle();

    // Enough port-0 completions to saturate its counter.
    for (int i = 0; i < 300; i++)
      applyStimulus(0, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));
    waitIdle();
    checkOutput("stat0_saturated", int'(stat0_cnt), exp_sat);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/alu_rr_sequencer.md
Name: alu_rr_sequencer

Overview:
- Shares one 4-bit, 12-function ALU datapath between two requesters (port 0, port 1).
- Round-robin arbitration, registered operand capture, one-cycle execute, and a held response with valid/ready backpressure.
- Sits between command sources (e.g. testbench drivers or a control FSM) and the shared ALU result consumer.

Parameters:
- OPW, 4, operand width (fixed at 4; other values unsupported).
- RESW, 7, result width.
- OPCW, 4, opcode width.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req0_valid  input  1  requester 0 command valid.
- req0_ready  output  1  requester 0 command accepted this cycle.
- req0_op  input  4  requester 0 opcode.
- req0_a  input  4  requester 0 operand a.
- req0_b  input  4  requester 0 operand b.
- req1_valid / req1_ready / req1_op / req1_a / req1_b  same as port 0, for requester 1.
- resp_valid  output  1  result available.
- resp_ready  input  1  consumer accepts result.
- resp_data  output  7  ALU result.
- resp_id  output  1  requester index that issued the command.
- resp_err  output  1  illegal opcode or divide by zero.
- stat0_cnt  output  8  requester 0 completions (ALU_STATS_EN only; 0 otherwise).
- stat1_cnt  output  8  requester 1 completions (ALU_STATS_EN only; 0 otherwise).

Behaviour:
- Reset:
  - Outputs: resp_valid=0, resp_data=0, resp_id=0, resp_err=0, req*_ready=0, stat*_cnt=0.
  - State: state=IDLE, rr pointer=0 (port 0 favoured).
- FSM states: IDLE, EXEC, RESP.
- IDLE: grant computed combinationally.
  - Only one valid: that port is granted.
  - Both valid: the rr-favoured port is granted.
  - reqX_ready = (state==IDLE) && grantX. At most one ready per cycle; no ready when no valid.
- Accept (valid && ready): capture op, a, b and grant index into registers; go to EXEC.
- EXEC (one cycle): compute the result from the captured operands; register resp_data, resp_err and resp_id; go to RESP.
- RESP:
  - resp_valid=1. resp_data, resp_id and resp_err are held stable until resp_ready=1.
  - On resp_valid && resp_ready: go to IDLE and set rr = ~resp_id, so the other port is favoured next.
- Timing:
  - Accept-to-resp_valid latency is 2 clocks.
  - Maximum throughput is one command per 3 clocks.
  - A new request is never accepted in EXEC or RESP.
- Opcodes: operands are zero-extended to 7 bits and results are truncated mod 128.
  - 0: a+b
  - 1: a-b (wraps, e.g. 2-5 = 7'h7D)
  - 2: a*b
  - 3: a/b (integer)
  - 4: a<<1
  - 5: a>>1
  - 6: a&b
  - 7: a|b
  - 8: a^b
  - 9: ~(a|b)
  - 10: ~(a&b)
  - 11: ~(a^b)
  - Opcodes 9–11 invert over all 7 bits, e.g. ~(0|0) = 7'h7F.
- Errors:
  - Opcode 3 with b=0: resp_data=7'h7F, resp_err=1.
  - Opcodes 12–15: resp_data=0, resp_err=1.
  - All other cases: resp_err=0.
- A requester that holds valid without being granted must keep op, a and b stable.
- resp_ready asserted while resp_valid=0 is ignored.
- Reset asserted mid-operation: immediate return to reset values. The in-flight command is dropped and produces no response.

Optional Feature:
- Macro: ALU_STATS_EN.
- Defined:
  - stat0_cnt and stat1_cnt increment on each response handshake for the matching resp_id.
  - The counters saturate at 8'hFF and clear only on reset.
- Undefined: no counter registers are built; stat0_cnt and stat1_cnt are tied to 0.

Test Plan:
- Port 0 sends op=0, a=9, b=8, resp_ready=1 -> resp_valid 2 clocks after accept; resp_data=17, resp_id=0, resp_err=0; back in IDLE the next cycle.
- Both ports valid from reset (p0 op=2 a=15 b=15; p1 op=1 a=2 b=5), held continuously -> p0 is served first with 225 mod 128 = 97; p1 next with 7'h7D, resp_id=1; then alternating order.
- Port 1 sends op=3, a=7, b=0 -> resp_data=7'h7F, resp_err=1. Op=13 -> resp_data=0, resp_err=1.
- Response with resp_ready=0 for 5 cycles while port 0 is valid -> resp_valid and resp_data remain stable and req0_ready stays 0. Raising resp_ready completes the response and p0 is accepted in the following IDLE cycle.
- rst_n pulsed low during EXEC -> all outputs return to reset values and no resp_valid follows for the dropped command.
- With ALU_STATS_EN: 3 port-0 and 2 port-1 completions -> stat0_cnt=3, stat1_cnt=2. 300 port-0 completions -> stat0_cnt=8'hFF. Without the macro, both counters read 0 throughout.
